partial_sum_buffer: RTL
=======================

// Module: partial_sum_buffer
// PURPOSE
//   Partial-sum storage and sequencer for the conv accumulator of one filter.
//   Holds one running sum per output pixel of the next IFM across all input channels.
//   It drives the adder's bias/feedback select (accu_enable) and its feedback operand (data_in_from_next).
//   It writes the adder sum (accu_data_out) back to storage.
//   On the last channel it streams finished pixels to the next stage over valid/ready.
// PARAMETERS
//   DATA_WIDTH            32   FP word width
//   IFM_SIZE              14   input feature-map side
//   KERNAL_SIZE           5    kernel side
//   IFM_DEPTH             3    input channels accumulated per filter
//   IFM_SIZE_NEXT         IFM_SIZE-KERNAL_SIZE+1               output side (derived)
//   ADDRESS_SIZE_NEXT_IFM $clog2(IFM_SIZE_NEXT*IFM_SIZE_NEXT)  pixel address width (derived)
//   NUMBER_OF_BITS_CHANNELS $clog2(IFM_DEPTH)+1                channel counter width (derived)
// PORTS
//   clk                 in   1      clock, all state on rising edge
//   reset               in   1      asynchronous, active-low reset
//   start               in   1      pulse: begin one filter pass (ignored unless idle)
//   conv_valid          in   1      conv result for current pixel present at adder input
//   conv_ready          out  1      buffer accepts adder sum this cycle
//   accu_data_out       in   DW     adder sum (conv + bias or conv + stored partial)
//   accu_enable         out  1      0: adder uses bias (channel 0); 1: uses data_in_from_next
//   data_in_from_next   out  DW     stored partial sum for current pixel (combinational read)
//   out_valid           out  1      finished pixel available
//   out_data            out  DW     finished pixel value
//   out_ready           in   1      next stage accepts out_data
//   busy                out  1      pass in progress (state != IDLE)
//   done                out  1      one-cycle pulse after final pixel accepted downstream
// BEHAVIOUR
// - Reset (async, reset=0):
//   - state=IDLE, pix_cnt=0, chan_cnt=0.
//   - conv_ready, out_valid, out_data, accu_enable, busy, done all 0.
//   - Storage RAM is not reset; channel 0 never reads it.
// - States:
//   - IDLE -start-> ACCUM (pix_cnt=0, chan_cnt=0).
//   - ACCUM -last beat of last channel accepted-> DRAIN.
//   - DRAIN -out_valid&&out_ready, or !out_valid-> DONE.
//   - DONE -> IDLE after 1 cycle; done=1 only in DONE.
// - Combinational outputs:
//   - conv_ready = (state==ACCUM) && (!out_valid || out_ready).
//   - accu_enable = (chan_cnt!=0).
//   - data_in_from_next = mem[pix_cnt].
// - Beat = conv_valid && conv_ready, sampled at the clock edge:
//   - mem[pix_cnt] <= accu_data_out (every channel).
//   - If chan_cnt==IFM_DEPTH-1: out_data <= accu_data_out, out_valid <= 1.
//   - pix_cnt wraps IFM_SIZE_NEXT^2-1 -> 0; on wrap chan_cnt++.
//   - Wrap on last channel -> DRAIN, counters cleared.
// - Output register is single entry:
//   - Cleared by out_ready when no new beat is loaded.
//   - A simultaneous pop and load keeps out_valid=1 with new data.
//   - out_data is held stable while out_valid && !out_ready.
// - Latency: sum at a beat edge appears on out_data at that edge (1 cycle); readback valid the next cycle.
// - Timing and arithmetic:
//   - No arithmetic in this block; the adder is external and combinational.
//   - Address counts row-major over the output map.
// - Boundaries:
//   - start while busy: ignored.
//   - conv_valid outside ACCUM: ignored (conv_ready=0).
//   - IFM_DEPTH=1: every beat uses bias and emits output.
//   - Reset mid-pass: aborts to IDLE; no done pulse.
// TESTING (IFM_SIZE=4, KERNAL_SIZE=3 -> 4 pixels, IFM_DEPTH=2; bench models adder)
// - Reset with all inputs 0:
//   - out_valid=0, conv_ready=0, accu_enable=0, busy=0, done=0.
//   - Same values hold for 5 cycles.
// - start, 4 beats, sums 3F800000, 40000000, 40400000, 40800000:
//   - accu_enable=0 on each beat, no out_valid.
//   - chan_cnt=1 after 4th beat.
// - Channel 1 pass, out_ready=1:
//   - data_in_from_next reads 3F800000, 40000000, 40400000, 40800000 in order, accu_enable=1.
//   - out_data equals each beat's accu_data_out.
//   - done pulses exactly once, busy falls.
// - Backpressure, out_ready=0 in channel 1:
//   - After first beat, conv_ready=0 and out_data holds.
//   - Raise out_ready: next beat accepted the same cycle, no lost or duplicated pixel.
// - Rebuild with IFM_DEPTH=1:
//   - 4 beats, all with accu_enable=0, each produces out_valid.
//   - done follows the 4th accepted output.
// - Abort and restart:
//   - start while busy: no counter change.
//   - reset=0 after pixel 2 of channel 1: state IDLE, no done.
//   - New start: accu_enable=0 on first beat.

Source files
------------

// File: rtl/partial_sum_buffer.sv
// Partial-sum store and sequencer for one conv filter's accumulator.
// Keeps a running sum per output pixel and streams final sums out.
module partial_sum_buffer #(
    parameter int DATA_WIDTH              = 32,
    parameter int IFM_SIZE                = 14,
    parameter int KERNAL_SIZE             = 5,
    parameter int IFM_DEPTH               = 3,
    parameter int IFM_SIZE_NEXT           = IFM_SIZE - KERNAL_SIZE + 1,
    parameter int ADDRESS_SIZE_NEXT_IFM   =
        $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT),
    parameter int NUMBER_OF_BITS_CHANNELS = $clog2(IFM_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  conv_valid,
    output logic                  conv_ready,
    input  logic [DATA_WIDTH-1:0] accu_data_out,
    output logic                  accu_enable,
    output logic [DATA_WIDTH-1:0] data_in_from_next,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int NPIX = IFM_SIZE_NEXT * IFM_SIZE_NEXT;
    localparam int AW   = ADDRESS_SIZE_NEXT_IFM;
    localparam int CW   = NUMBER_OF_BITS_CHANNELS;

    localparam logic [AW-1:0] LAST_PIX  = AW'(NPIX - 1);
    localparam logic [CW-1:0] LAST_CHAN = CW'(IFM_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state;
    logic [AW-1:0]           pix_cnt;
    logic [CW-1:0]           chan_cnt;
    logic [DATA_WIDTH-1:0]   mem [NPIX];

    logic beat;
    logic last_chan;
    logic last_pix;

    assign conv_ready = (state == S_ACCUM) && (!out_valid || out_ready);
    assign beat       = conv_valid && conv_ready;
    assign last_chan  = (chan_cnt == LAST_CHAN);
    assign last_pix   = (pix_cnt == LAST_PIX);

    assign accu_enable       = (chan_cnt != '0);
    assign data_in_from_next = mem[pix_cnt];
    assign busy              = (state != S_IDLE);
    assign done              = (state == S_DONE);

    // Storage is never reset: channel 0 takes the bias path and never reads it.
    always_ff @(posedge clk) begin
        if (beat) begin
            mem[pix_cnt] <= accu_data_out;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            pix_cnt  <= '0;
            chan_cnt <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_ACCUM;
                        pix_cnt  <= '0;
                        chan_cnt <= '0;
                    end
                end
                S_ACCUM: begin
                    if (beat) begin
                        if (last_pix) begin
                            pix_cnt <= '0;
                            if (last_chan) begin
                                chan_cnt <= '0;
                                state    <= S_DRAIN;
                            end else begin
                                chan_cnt <= chan_cnt + 1'b1;
                            end
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!out_valid || out_ready) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Single-entry output register; a pop and a load in one cycle stays full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (beat && last_chan) begin
            out_valid <= 1'b1;
            out_data  <= accu_data_out;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
